// File: rtl/muldiv_seq.sv
// Iterative RV32M unit: radix-2 shift-add multiply and restoring divide, one op at a time.
// Holds the pipeline via stallE while the XLEN-cycle loop runs; the result is valid for one cycle with doneE.
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            startE,
  input  logic [2:0]      funct3E,
  input  logic [XLEN-1:0] srcAE,
  input  logic [XLEN-1:0] srcBE,
  input  logic            flushE,
  output logic            stallE,
  output logic            doneE,
  output logic [XLEN-1:0] resultE,
  output logic [1:0]      dbg_state_o
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_DONE = 2'd3} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        f3_q, f3_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   result_q, result_d;

  // Operand decode for a new op
  logic            is_div, sgn_a, sgn_b, a_neg, b_neg;
  logic [XLEN-1:0] abs_a, abs_b;

  assign is_div = funct3E[2];
  assign sgn_a  = is_div ? ~funct3E[0] : (funct3E[1:0] != 2'b11);
  assign sgn_b  = is_div ? ~funct3E[0] : ~funct3E[1];
  assign a_neg  = sgn_a & srcAE[XLEN-1];
  assign b_neg  = sgn_b & srcBE[XLEN-1];
  assign abs_a  = a_neg ? ('0 - srcAE) : srcAE;
  assign abs_b  = b_neg ? ('0 - srcBE) : srcBE;

  // One multiply step: conditional add into the upper half, then shift right with carry
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_nx, mul_prod;

  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign mul_nx   = {mul_sum, acc_q[XLEN-1:1]};
  assign mul_prod = neg_q ? ('0 - mul_nx) : mul_nx;

  // One restoring-divide step on {remainder, dividend}; the quotient shifts in at the bottom
  logic [XLEN:0]     div_hi, div_trial;
  logic [2*XLEN-1:0] div_nx;
  logic [XLEN-1:0]   div_sel;

  assign div_hi    = acc_q[2*XLEN-1:XLEN-1];
  assign div_trial = div_hi - {1'b0, opb_q};
  assign div_nx    = div_trial[XLEN] ? {div_hi[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                     : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
  assign div_sel   = f3_q[1] ? div_nx[2*XLEN-1:XLEN] : div_nx[XLEN-1:0];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    f3_d     = f3_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    neg_d    = neg_q;
    result_d = result_q;
    unique case (state_q)
      S_IDLE: begin
        if (startE && !flushE) begin
          f3_d  = funct3E;
          cnt_d = CW'(XLEN);
          neg_d = (is_div && funct3E[1]) ? a_neg : (a_neg ^ b_neg);
          if (!is_div) begin
            acc_d   = {{XLEN{1'b0}}, abs_b};
            opb_d   = abs_a;
            state_d = S_MUL;
          end else if (srcBE == '0) begin
            result_d = funct3E[1] ? srcAE : '1;
            state_d  = S_DONE;
          end else begin
            acc_d   = {{XLEN{1'b0}}, abs_a};
            opb_d   = abs_b;
            state_d = S_DIV;
          end
        end
      end
      S_MUL: begin
        acc_d = mul_nx;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          result_d = (f3_q[1:0] == 2'b00) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];
          state_d  = S_DONE;
        end
      end
      S_DIV: begin
        acc_d = div_nx;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          result_d = neg_q ? ('0 - div_sel) : div_sel;
          state_d  = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flushE) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      f3_q     <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      f3_q     <= f3_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  // Pipeline advances exactly in the cycle the result is presented
  assign stallE      = ((state_q == S_IDLE) && startE && !flushE) ||
                       (state_q == S_MUL) || (state_q == S_DIV);
  assign doneE       = (state_q == S_DONE) && !flushE;
  assign resultE     = result_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative sequencer for the RV32M extension in the execute stage. It accepts one multiply or divide operation at a time and runs a radix-2 shift-add or restoring-divide loop for XLEN cycles.
- While the loop runs, it stalls the pipeline through `stallE`.
- When the result is ready, it presents it for one cycle, and the ResultSrc path muxes it in ahead of the ALU output.
- Controls (start, funct3) come from the decode path alongside the main decoder outputs; the hazard unit consumes `stallE`.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
startE  input  1  valid M-extension op in E stage (opcode 0110011, funct7 0000001)
funct3E  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
srcAE  input  XLEN  rs1 operand (forwarded)
srcBE  input  XLEN  rs2 operand (forwarded)
flushE  input  1  squash current op
stallE  output  1  pipeline stall request (combinational)
doneE  output  1  result valid, single-cycle pulse
resultE  output  XLEN  product/quotient/remainder

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; counter, accumulators and resultE cleared to 0; doneE=0.
  - Asserting reset mid-operation aborts the operation immediately; there is no done pulse after release.
- States: IDLE, MUL, DIV, DONE. State, operands and op code are all registered.
- IDLE:
  - On startE=1 and flushE=0, latch funct3, the operands (as absolute values where signed), the result sign and the op type.
  - MUL group -> MUL; DIV group -> DIV, except divisor==0 -> DONE directly.
  - Counter loads XLEN.
- MUL:
  - Each cycle: if multiplier LSB is set, add multiplicand to the upper half of a 2*XLEN accumulator, then shift right 1. Decrement counter.
  - At counter==1 -> DONE.
  - Signedness: MUL/MULH both signed; MULHSU rs1 signed, rs2 unsigned; MULHU unsigned.
  - Negate the 2*XLEN product if the result sign is set.
  - MUL returns the low XLEN bits; the others return the high XLEN bits.
- DIV:
  - Restoring division: shift the {remainder,dividend} pair left 1, trial-subtract the divisor, set the quotient bit on no-borrow. Decrement counter.
  - At counter==1 -> DONE.
  - Signed ops: quotient sign = sign(rs1) XOR sign(rs2); remainder sign = sign(rs1).
  - Unsigned ops use raw operands.
- Divide-by-zero:
  - Quotient = all ones (DIV and DIVU); remainder = rs1 unmodified.
  - Total latency is 1 cycle in IDLE plus DONE.
- Signed overflow (-2^XLEN-1 / -1): quotient = 0x80000000, remainder = 0. This falls out of the magnitude algorithm and must be checked.
- DONE:
  - doneE=1 and resultE valid for exactly this cycle; next state is IDLE.
  - startE in DONE is ignored, because it is the same instruction advancing.
- stallE:
  - 1 when (state==IDLE and startE and not flushE), or state in {MUL, DIV}.
  - 0 in DONE, so the pipeline advances exactly when doneE=1.
- Latency:
  - Start seen at cycle 0 (IDLE); loop occupies cycles 1..XLEN; DONE at cycle XLEN+1 (33 for XLEN=32).
  - Divide-by-zero reaches DONE at cycle 1.
- flushE:
  - In any state, flushE=1 returns the FSM to IDLE on the next edge; doneE stays 0 and the partial result is discarded.
  - flushE together with startE in IDLE means the op is not accepted.
- resultE holds its last value outside DONE; consumers use it only with doneE.

Test Plan:
- MUL 7 * 0xFFFFFFFD (-3), start at cycle 0 -> stallE high cycles 0..32, doneE at cycle 33, resultE=0xFFFFFFEB.
- MULH 0x80000000 * 0x80000000 -> 0x40000000. MULHU of the same operands -> 0x40000000. MULHSU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD. REM of the same operands -> 0xFFFFFFFF. DIVU 0xFFFFFFF9 / 2 -> 0x7FFFFFFC.
- DIVU 100 / 0 -> doneE at cycle 1, resultE=0xFFFFFFFF. REM 100 / 0 -> 100. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM of the same operands -> 0.
- Start DIV, assert flushE at cycle 10 -> IDLE at cycle 11, no doneE; a new MUL 3*5 at cycle 12 -> doneE at cycle 45, resultE=15.
- Drop rst_n at cycle 5 of a MUL -> state IDLE, doneE=0, resultE=0 immediately; no done pulse after release.
